// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous double buffering.
// Define SEG7_LZB_EN to enable leading-zero blanking of the shadow data.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 100000,
   parameter int unsigned GUARD_CYC  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank_in,
   input  logic                      hex_mode,
   input  logic                      load,
   output logic                      busy,
   output logic                      frame_tick,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     an
);

   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam int unsigned VW = 4 * NUM_DIGITS;

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [VW-1:0]         pend_val;
   logic [NUM_DIGITS-1:0] pend_dp;
   logic [NUM_DIGITS-1:0] pend_blank;
   logic [VW-1:0]         sh_val;
   logic [NUM_DIGITS-1:0] sh_dp;
   logic [NUM_DIGITS-1:0] sh_blank;

   logic                  slot_end_c;
   logic                  last_digit_c;
   logic                  boundary_c;
   logic                  pre_boundary_c;
   logic                  lit_c;
   logic                  dark_c;
   logic [3:0]            nib_c;
   logic [VW-1:0]         next_val_c;
   logic [NUM_DIGITS-1:0] next_dp_c;
   logic [NUM_DIGITS-1:0] next_blank_c;

   // Segment patterns {g,f,e,d,c,b,a}, active low; A..F only light up in hex mode.
   function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
      logic [6:0] s;
      s = 7'b1111111;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = hex ? 7'b0001000 : 7'b1111111;
         4'hB: s = hex ? 7'b0000011 : 7'b1111111;
         4'hC: s = hex ? 7'b1000110 : 7'b1111111;
         4'hD: s = hex ? 7'b0100001 : 7'b1111111;
         4'hE: s = hex ? 7'b0000110 : 7'b1111111;
         4'hF: s = hex ? 7'b0001110 : 7'b1111111;
      endcase
      return s;
   endfunction

`ifdef SEG7_LZB_EN
   logic [NUM_DIGITS-1:0] lzb;

   // Walk from the most significant nibble down; digit 0 is never blanked.
   function automatic logic [NUM_DIGITS-1:0] lzb_of(input logic [VW-1:0] v);
      logic [NUM_DIGITS-1:0] m;
      logic [VW-1:0]         t;
      logic                  lead;
      m    = '0;
      t    = v;
      lead = 1'b1;
      for (int i = 1; i < int'(NUM_DIGITS); i++) begin
         lead = lead & (t[VW-1 -: 4] == 4'h0);
         m    = (m << 1) | NUM_DIGITS'(lead);
         t    = t << 4;
      end
      return m << 1;
   endfunction
`endif

   always_comb begin
      slot_end_c     = (cnt == CW'(SCAN_DIV - 1));
      last_digit_c   = (idx == IW'(NUM_DIGITS - 1));
      boundary_c     = slot_end_c & last_digit_c;
      pre_boundary_c = (cnt == CW'(SCAN_DIV - 2)) & last_digit_c;
      lit_c          = (cnt >= CW'(GUARD_CYC));
      nib_c          = sh_val[{idx, 2'b00} +: 4];
      next_val_c     = load ? value    : pend_val;
      next_dp_c      = load ? dp_in    : pend_dp;
      next_blank_c   = load ? blank_in : pend_blank;
`ifdef SEG7_LZB_EN
      dark_c         = sh_blank[idx] | lzb[idx];
`else
      dark_c         = sh_blank[idx];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         sh_val     <= '0;
         sh_dp      <= '0;
         sh_blank   <= '0;
         busy       <= 1'b0;
         frame_tick <= 1'b0;
         an         <= '1;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
`ifdef SEG7_LZB_EN
         lzb        <= lzb_of('0);
`endif
      end else begin
         cnt <= slot_end_c ? '0 : cnt + CW'(1);
         if (slot_end_c)
            idx <= last_digit_c ? '0 : idx + IW'(1);

         // Registered one cycle early so the pulse lands on the boundary cycle itself.
         frame_tick <= pre_boundary_c;

         if (load) begin
            pend_val   <= value;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
         end

         // A load coinciding with the boundary bypasses pending straight into shadow.
         if (boundary_c) begin
            sh_val   <= next_val_c;
            sh_dp    <= next_dp_c;
            sh_blank <= next_blank_c;
            busy     <= 1'b0;
`ifdef SEG7_LZB_EN
            lzb      <= lzb_of(next_val_c);
`endif
         end else if (load) begin
            busy <= 1'b1;
         end

         an  <= lit_c ? ~(NUM_DIGITS'(1) << idx) : '1;
         seg <= dark_c ? 7'b1111111 : decode(nib_c, hex_mode);
         dp  <= sh_blank[idx] ? 1'b1 : ~sh_dp[idx];
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle guard).
// Expectations honour SEG7_LZB_EN when the bench is built with it defined.
module tb_seg7_scan_driver;

   localparam int unsigned ND = 4;
   localparam int unsigned SD = 8;
   localparam int unsigned GC = 2;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b1000110;
   localparam logic [6:0] SF = 7'b0001110;
   localparam logic [6:0] DK = 7'b1111111;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   value;
   logic [3:0]    dp_in;
   logic [3:0]    blank_in;
   logic          hex_mode;
   logic          load;
   logic          busy;
   logic          frame_tick;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    an;

   int checks   = 0;
   int failures = 0;

   seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYC(GC)) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .hex_mode   (hex_mode),
      .load       (load),
      .busy       (busy),
      .frame_tick (frame_tick),
      .seg        (seg),
      .dp         (dp),
      .an         (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value    = v;
      dp_in    = d;
      blank_in = b;
      load     = 1'b1;
      tick();
      load     = 1'b0;
   endtask

   // Stops on the frame-boundary cycle (state cnt=7, idx=3).
   task automatic wait_frame();
      for (int i = 0; i < 40 && frame_tick !== 1'b1; i++) tick();
      check("wait_frame_tick", 32'(frame_tick), 32'(1'b1));
   endtask

   // Call one cycle past the boundary edge; es holds digit d at bits [7d+6:7d].
   task automatic check_frame(input string tag, input logic [27:0] es, input logic [3:0] edp);
      logic [27:0] sh;
      logic [3:0]  ea;
      for (int d = 0; d < int'(ND); d++) begin
         sh = es >> (7 * d);
         ea = ~(4'b0001 << d);
         for (int c = 0; c < int'(SD); c++) begin
            tick();
            if (c < int'(GC))
               check($sformatf("%s_an_guard_d%0d_c%0d", tag, d, c), 32'(an), 32'(4'hF));
            else if (c == int'(GC) || c == int'(SD) - 1) begin
               check($sformatf("%s_an_d%0d_c%0d", tag, d, c), 32'(an), 32'(ea));
               check($sformatf("%s_seg_d%0d_c%0d", tag, d, c), 32'(seg), 32'(sh[6:0]));
               check($sformatf("%s_dp_d%0d_c%0d", tag, d, c), 32'(dp), 32'(edp[d]));
            end
         end
      end
   endtask

   initial begin
      logic [27:0] exp_lz;
      value    = '0;
      dp_in    = '0;
      blank_in = '0;
      hex_mode = 1'b0;
      load     = 1'b0;
      rst      = 1'b1;

      // Reset values and start-up timing
      repeat (3) tick();
      check("rst_an", 32'(an), 32'(4'hF));
      check("rst_seg", 32'(seg), 32'(DK));
      check("rst_dp", 32'(dp), 32'(1'b1));
      check("rst_busy", 32'(busy), 32'(1'b0));
      check("rst_frame_tick", 32'(frame_tick), 32'(1'b0));
      rst = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k <= 2) check($sformatf("start_an_off_%0d", k), 32'(an), 32'(4'hF));
         if (k == 3) begin
            check("start_an0", 32'(an), 32'(4'b1110));
            check("start_seg0", 32'(seg), 32'(S0));
         end
         if (k == 30 || k == 32 || k == 62)
            check($sformatf("ft_low_%0d", k), 32'(frame_tick), 32'(1'b0));
         if (k == 31 || k == 63)
            check($sformatf("ft_high_%0d", k), 32'(frame_tick), 32'(1'b1));
      end

      // BCD scan
      do_load(16'h1234, 4'h0, 4'h0);
      check("bcd_busy_set", 32'(busy), 32'(1'b1));
      wait_frame();
      check("bcd_busy_at_boundary", 32'(busy), 32'(1'b1));
      tick();
      check("bcd_busy_clear", 32'(busy), 32'(1'b0));
      check_frame("bcd", {S1, S2, S3, S4}, 4'hF);

      // Hex decode, then the same data in BCD mode
      hex_mode = 1'b1;
      do_load(16'hABCF, 4'h0, 4'h0);
      wait_frame();
      tick();
      check_frame("hex", {SA, SB, SC, SF}, 4'hF);
      hex_mode = 1'b0;
      wait_frame();
      tick();
      check_frame("hex_as_bcd", {DK, DK, DK, DK}, 4'hF);

      // Double buffering: two mid-frame loads, last wins, old frame untouched
      hex_mode = 1'b1;
      repeat (10) tick();
      do_load(16'h1111, 4'h0, 4'h0);
      check("dbuf_busy1", 32'(busy), 32'(1'b1));
      tick();
      do_load(16'h2222, 4'h0, 4'h0);
      check("dbuf_busy2", 32'(busy), 32'(1'b1));
      wait_frame();
      check("dbuf_old_seg", 32'(seg), 32'(SA));
      check("dbuf_old_an", 32'(an), 32'(4'b0111));
      check("dbuf_busy_boundary", 32'(busy), 32'(1'b1));
      tick();
      check_frame("dbuf_new", {S2, S2, S2, S2}, 4'hF);

      // Load on the boundary cycle goes straight to shadow
      wait_frame();
      do_load(16'h5555, 4'h0, 4'h0);
      check("bnd_load_busy", 32'(busy), 32'(1'b0));
      check_frame("bnd_load", {S5, S5, S5, S5}, 4'hF);
      check("bnd_load_busy_after", 32'(busy), 32'(1'b0));

      // Decimal-point and blank masks
      do_load(16'h8888, 4'b0100, 4'b0001);
      wait_frame();
      tick();
      check_frame("mask", {S8, S8, S8, DK}, 4'b1011);

      // Leading zeros
      do_load(16'h0070, 4'h0, 4'h0);
      wait_frame();
      tick();
`ifdef SEG7_LZB_EN
      exp_lz = {DK, DK, S7, S0};
`else
      exp_lz = {S0, S0, S7, S0};
`endif
      check_frame("lz_0070", exp_lz, 4'hF);
      do_load(16'h0000, 4'h0, 4'h0);
      wait_frame();
      tick();
`ifdef SEG7_LZB_EN
      exp_lz = {DK, DK, DK, S0};
`else
      exp_lz = {S0, S0, S0, S0};
`endif
      check_frame("lz_0000", exp_lz, 4'hF);

      // Reset mid-load discards the pending data
      do_load(16'h1234, 4'hF, 4'h0);
      check("rl_busy_set", 32'(busy), 32'(1'b1));
      rst = 1'b1;
      tick();
      check("rl_an", 32'(an), 32'(4'hF));
      check("rl_seg", 32'(seg), 32'(DK));
      check("rl_dp", 32'(dp), 32'(1'b1));
      check("rl_busy", 32'(busy), 32'(1'b0));
      check("rl_frame_tick", 32'(frame_tick), 32'(1'b0));
      rst = 1'b0;
      check_frame("rl_zero", exp_lz, 4'hF);
      check("rl_busy_after", 32'(busy), 32'(1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
